// File: rtl/lsu_mem_ctrl.sv
// MEM-stage load/store controller driving a registered data memory; byte loads are sign/zero-extended.
// Optional LSU_MISALIGN_TRAP_EN: reject misaligned word requests instead of forcing addr[1:0]=0.
module lsu_mem_ctrl #(
  parameter logic [31:0] MEM_BASE  = 32'h8002_0000,
  parameter logic [31:0] MEM_BYTES = 32'h0020_0000,
  parameter int          RD_W      = 5,
  parameter logic [1:0]  SZ_WORD   = 2'b00,
  parameter logic [1:0]  SZ_BYTE   = 2'b11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_load,
  input  logic            req_byte,
  input  logic            req_signed,
  input  logic [31:0]     req_addr,
  input  logic [31:0]     req_wdata,
  input  logic [RD_W-1:0] req_rd,
  output logic            resp_valid,
  output logic [31:0]     resp_data,
  output logic [RD_W-1:0] resp_rd,
  output logic            err_addr,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wdata,
  output logic [1:0]      mem_size,
  output logic            mem_rd_wr,
  output logic            mem_enable,
  input  logic [31:0]     mem_rdata,
  input  logic            mem_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT} state_t;

  state_t            state_q, state_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, resp_data_q, resp_data_d;
  logic              byte_q, byte_d, load_q, load_d, signed_q, signed_d;
  logic              resp_valid_q, resp_valid_d, err_q, err_d;
  logic [RD_W-1:0]   rd_q, rd_d, resp_rd_q, resp_rd_d;
  logic              in_range, reject;

  always_comb begin
    in_range = (req_addr >= MEM_BASE) && ((req_addr - MEM_BASE) < MEM_BYTES);
`ifdef LSU_MISALIGN_TRAP_EN
    reject   = !in_range || (!req_byte && (req_addr[1:0] != 2'b00));
`else
    reject   = !in_range;
`endif
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    byte_d       = byte_q;
    load_d       = load_q;
    signed_d     = signed_q;
    rd_d         = rd_q;
    resp_data_d  = resp_data_q;
    resp_rd_d    = resp_rd_q;
    resp_valid_d = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        if (reject) begin
          err_d = 1'b1;
        end else begin
          // Word accesses are forced aligned; byte stores only carry the low byte.
          addr_d   = req_byte ? req_addr : {req_addr[31:2], 2'b00};
          wdata_d  = req_byte ? {24'b0, req_wdata[7:0]} : req_wdata;
          byte_d   = req_byte;
          load_d   = req_load;
          signed_d = req_signed;
          rd_d     = req_rd;
          state_d  = ISSUE;
        end
      end
      ISSUE: if (!mem_busy) state_d = load_q ? CAPT : IDLE;
      CAPT: begin
        // Memory read data is still valid at this edge; it goes Z only afterwards.
        resp_data_d  = !byte_q ? mem_rdata :
                       signed_q ? {{24{mem_rdata[7]}}, mem_rdata[7:0]} : {24'b0, mem_rdata[7:0]};
        resp_rd_d    = rd_q;
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      byte_q       <= 1'b0;
      load_q       <= 1'b1;
      signed_q     <= 1'b0;
      rd_q         <= '0;
      resp_data_q  <= '0;
      resp_rd_q    <= '0;
      resp_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      byte_q       <= byte_d;
      load_q       <= load_d;
      signed_q     <= signed_d;
      rd_q         <= rd_d;
      resp_data_q  <= resp_data_d;
      resp_rd_q    <= resp_rd_d;
      resp_valid_q <= resp_valid_d;
      err_q        <= err_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign mem_enable = (state_q == ISSUE);
  assign mem_rd_wr  = (state_q == ISSUE) ? load_q : 1'b1;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;
  assign mem_size   = byte_q ? SZ_BYTE : SZ_WORD;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_rd    = resp_rd_q;
  assign err_addr   = err_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl with a big-endian registered memory model.
module tb_lsu_mem_ctrl;
  localparam logic [1:0] SZB = 2'b11;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 0, req_load = 0, req_byte = 0, req_signed = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic [4:0]  req_rd = 0;
  logic        req_ready, resp_valid, err_addr, mem_rd_wr, mem_enable;
  logic [31:0] resp_data, mem_addr, mem_wdata;
  logic [4:0]  resp_rd;
  logic [1:0]  mem_size;
  logic [31:0] mem_rdata = 'z;
  logic        mem_busy = 1'b0;

  lsu_mem_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
    .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd), .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
    .err_addr(err_addr), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size),
    .mem_rd_wr(mem_rd_wr), .mem_enable(mem_enable), .mem_rdata(mem_rdata), .mem_busy(mem_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: byte at the lowest address is the MSB of a word; byte reads carry junk above [7:0].
  logic [7:0] mm [0:4095];
  initial for (int i = 0; i < 4096; i++) mm[i] = 8'h00;
  always @(posedge clk) begin
    if (mem_enable && !mem_busy) begin
      if (mem_rd_wr)
        mem_rdata <= (mem_size == SZB) ? {24'hA5A5A5, mm[mem_addr[11:0]]} :
                     {mm[mem_addr[11:0]], mm[mem_addr[11:0]+12'd1],
                      mm[mem_addr[11:0]+12'd2], mm[mem_addr[11:0]+12'd3]};
      else if (mem_size == SZB)
        mm[mem_addr[11:0]] <= mem_wdata[7:0];
      else begin
        mm[mem_addr[11:0]]       <= mem_wdata[31:24];
        mm[mem_addr[11:0]+12'd1] <= mem_wdata[23:16];
        mm[mem_addr[11:0]+12'd2] <= mem_wdata[15:8];
        mm[mem_addr[11:0]+12'd3] <= mem_wdata[7:0];
      end
    end else if (!mem_enable) begin
      mem_rdata <= 'z;
    end
  end

  typedef struct { bit is_err; logic [31:0] data; logic [4:0] rd; int due; } exp_t;
  exp_t sbq[$];
  exp_t e;
  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every resp_valid / err_addr cycle must match the next scoreboard entry.
  always @(negedge clk) begin
    if (resp_valid === 1'b1 || err_addr === 1'b1) begin
      if (sbq.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_output: resp_valid=%b err_addr=%b with nothing expected (cycle %0d)",
                 resp_valid, err_addr, cyc);
      end else begin
        e = sbq.pop_front();
        chk("out_kind_err", {31'b0, err_addr}, {31'b0, e.is_err});
        chk("out_kind_resp", {31'b0, resp_valid}, {31'b0, !e.is_err});
        chk("out_cycle", cyc, e.due);
        if (!e.is_err) begin
          chk("resp_data", resp_data, e.data);
          chk("resp_rd", {27'b0, resp_rd}, {27'b0, e.rd});
        end
      end
    end
  end

  task automatic wait_ready();
    int w = 0;
    while (req_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    if (req_ready !== 1'b1) chk("ready_timeout", {31'b0, req_ready}, 32'd1);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge (plus any busy cycles).
  task automatic issue(input bit ld, input bit bt, input bit sg, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd, input int busy,
                       input bit exp_err, input logic [31:0] exp_data);
    int n;
    exp_t x;
    wait_ready();
    req_valid = 1; req_load = ld; req_byte = bt; req_signed = sg;
    req_addr = a; req_wdata = wd; req_rd = rd;
    n = cyc + 1;
    x.is_err = exp_err; x.data = exp_data; x.rd = rd;
    x.due = exp_err ? n : n + 2 + busy;
    if (ld || exp_err) sbq.push_back(x);
    @(negedge clk);
    req_valid = 0;
    if (exp_err) begin
      chk("reject_no_enable", {31'b0, mem_enable}, 32'd0);
    end else if (busy > 0) begin
      mem_busy = 1;
      for (int i = 0; i < busy; i++) begin
        chk("busy_enable", {31'b0, mem_enable}, 32'd1);
        chk("busy_ready", {31'b0, req_ready}, 32'd0);
        @(negedge clk);
      end
      mem_busy = 0;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_rd", {27'b0, resp_rd}, 32'd0);
    chk("rst_err", {31'b0, err_addr}, 32'd0);
    chk("rst_enable", {31'b0, mem_enable}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_size", {30'b0, mem_size}, 32'd0);
    chk("rst_rd_wr", {31'b0, mem_rd_wr}, 32'd1);

    // word store / load
    issue(0, 0, 0, 32'h8002_0010, 32'hDEAD_BEEF, 5'd0, 0, 0, 0);
    issue(1, 0, 0, 32'h8002_0010, 32'h0, 5'd5, 0, 0, 32'hDEAD_BEEF);
    // byte loads with sign / zero extension
    issue(0, 0, 0, 32'h8002_0020, 32'h8011_2233, 5'd0, 0, 0, 0);
    issue(1, 1, 1, 32'h8002_0020, 32'h0, 5'd1, 0, 0, 32'hFFFF_FF80);
    issue(1, 1, 0, 32'h8002_0020, 32'h0, 5'd2, 0, 0, 32'h0000_0080);
    issue(1, 1, 1, 32'h8002_0022, 32'h0, 5'd3, 0, 0, 32'h0000_0022);
    // byte store writes only the addressed byte with wdata[7:0]
    issue(0, 1, 0, 32'h8002_0031, 32'h1234_56A5, 5'd0, 0, 0, 0);
    issue(1, 0, 0, 32'h8002_0030, 32'h0, 5'd4, 0, 0, 32'h00A5_0000);
    // busy stall of 3 cycles
    issue(1, 0, 0, 32'h8002_0010, 32'h0, 5'd6, 3, 0, 32'hDEAD_BEEF);
    // range boundaries
    issue(1, 0, 0, 32'h8001_FFFC, 32'h0, 5'd7, 0, 1, 0);
    issue(0, 0, 0, 32'h8022_0000, 32'h1111_1111, 5'd7, 0, 1, 0);
    issue(1, 1, 0, 32'h8021_FFFF, 32'h0, 5'd7, 0, 0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1, 0, 0, 32'h8002_0012, 32'h0, 5'd8, 0, 1, 0);
`else
    issue(1, 0, 0, 32'h8002_0012, 32'h0, 5'd8, 0, 0, 32'hDEAD_BEEF);
`endif
    // reset during CAPT of a load discards it
    wait_ready();
    req_valid = 1; req_load = 1; req_byte = 0; req_addr = 32'h8002_0010; req_rd = 5'd10;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rstcapt_ready", {31'b0, req_ready}, 32'd1);
    chk("rstcapt_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rstcapt_enable", {31'b0, mem_enable}, 32'd0);
    issue(1, 0, 0, 32'h8002_0020, 32'h0, 5'd9, 0, 0, 32'h8011_2233);

    repeat (8) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end
endmodule
